// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the CHIP-8 RAM arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 12;
  localparam int unsigned DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ACK
  } state_e;

  typedef enum logic [1:0] {
    REQ_CPU = 2'd0,
    REQ_GPU = 2'd1,
    REQ_VGA = 2'd2
  } req_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and RAM-side signal bundle; slave = arbiter view, master = requesters plus RAM.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_arbiter_pkg::DEF_DATA_W
);

  logic              cpu_read;
  logic [ADDR_W-1:0] cpu_read_addr;
  logic [DATA_W-1:0] cpu_read_data;
  logic              cpu_read_ack;
  logic              cpu_write;
  logic [ADDR_W-1:0] cpu_write_addr;
  logic [DATA_W-1:0] cpu_write_data;
  logic              cpu_write_ready;

  logic              gpu_read;
  logic [ADDR_W-1:0] gpu_read_addr;
  logic [DATA_W-1:0] gpu_read_data;
  logic              gpu_read_ack;
  logic              gpu_write;
  logic [ADDR_W-1:0] gpu_write_addr;
  logic [DATA_W-1:0] gpu_write_data;
  logic              gpu_write_ready;

  logic              vga_read;
  logic [ADDR_W-1:0] vga_addr;
  logic [DATA_W-1:0] vga_data;
  logic              vga_ack;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_read, cpu_read_addr, cpu_write, cpu_write_addr, cpu_write_data,
    output cpu_read_data, cpu_read_ack, cpu_write_ready,
    input  gpu_read, gpu_read_addr, gpu_write, gpu_write_addr, gpu_write_data,
    output gpu_read_data, gpu_read_ack, gpu_write_ready,
    input  vga_read, vga_addr,
    output vga_data, vga_ack,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_read, cpu_read_addr, cpu_write, cpu_write_addr, cpu_write_data,
    input  cpu_read_data, cpu_read_ack, cpu_write_ready,
    output gpu_read, gpu_read_addr, gpu_write, gpu_write_addr, gpu_write_data,
    input  gpu_read_data, gpu_read_ack, gpu_write_ready,
    output vga_read, vga_addr,
    input  vga_data, vga_ack,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/mem_arb_wbuf.sv
// One-entry write buffer: captures a write when empty, holds it until the arbiter drains it.
module mem_arb_wbuf #(
  parameter int unsigned ADDR_W = mem_arbiter_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = mem_arbiter_pkg::DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              write,
  input  logic [ADDR_W-1:0] write_addr,
  input  logic [DATA_W-1:0] write_data,
  output logic              write_ready,
  input  logic              drain,
  output logic              valid,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (drain) begin
      valid_d = 1'b0;
    end else if (write && !valid_q) begin
      valid_d = 1'b1;
      addr_d  = write_addr;
      data_d  = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign write_ready = !valid_q;
  assign valid       = valid_q;
  assign addr        = addr_q;
  assign data        = data_q;

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter for CPU, GPU and VGA scanout.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin CPU/GPU arbitration (default: CPU over GPU).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W      = DEF_ADDR_W,
  parameter int unsigned DATA_W      = DEF_DATA_W,
  parameter int unsigned RAM_LATENCY = 1
) (
  input logic          clk,
  input logic          rst_n,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0] WAIT_LAST = 2'(RAM_LATENCY - 1);

  state_e            state_q, state_d;
  req_e              grant_q, grant_d;
  logic              is_write_q, is_write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        wait_cnt_q, wait_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] gpu_rdata_q, gpu_rdata_d;
  logic [DATA_W-1:0] vga_rdata_q, vga_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic              rr_q, rr_d;
`endif

  logic              cpu_wvalid, gpu_wvalid;
  logic [ADDR_W-1:0] cpu_waddr, gpu_waddr;
  logic [DATA_W-1:0] cpu_wdata, gpu_wdata;
  logic              cpu_drain, gpu_drain;
  logic              cpu_req, gpu_req;
  logic              pick_cpu, pick_gpu;

  mem_arb_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cpu_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .write       (bus.cpu_write),
    .write_addr  (bus.cpu_write_addr),
    .write_data  (bus.cpu_write_data),
    .write_ready (bus.cpu_write_ready),
    .drain       (cpu_drain),
    .valid       (cpu_wvalid),
    .addr        (cpu_waddr),
    .data        (cpu_wdata)
  );

  mem_arb_wbuf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_gpu_wbuf (
    .clk         (clk),
    .rst_n       (rst_n),
    .write       (bus.gpu_write),
    .write_addr  (bus.gpu_write_addr),
    .write_data  (bus.gpu_write_data),
    .write_ready (bus.gpu_write_ready),
    .drain       (gpu_drain),
    .valid       (gpu_wvalid),
    .addr        (gpu_waddr),
    .data        (gpu_wdata)
  );

  // CPU/GPU selection; VGA precedence is applied in the IDLE state itself.
  always_comb begin
    cpu_req = cpu_wvalid || bus.cpu_read;
    gpu_req = gpu_wvalid || bus.gpu_read;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    pick_cpu = cpu_req && (!rr_q || !gpu_req);
`else
    pick_cpu = cpu_req;
`endif
    pick_gpu = gpu_req && !pick_cpu;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_q     <= REQ_CPU;
      is_write_q  <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wait_cnt_q  <= '0;
      cpu_rdata_q <= '0;
      gpu_rdata_q <= '0;
      vga_rdata_q <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= 1'b0;
`endif
    end else begin
      grant_q     <= grant_d;
      is_write_q  <= is_write_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wait_cnt_q  <= wait_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      gpu_rdata_q <= gpu_rdata_d;
      vga_rdata_q <= vga_rdata_d;
`ifdef MEM_ARB_ROUND_ROBIN_EN
      rr_q        <= rr_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    is_write_d  = is_write_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wait_cnt_d  = wait_cnt_q;
    cpu_rdata_d = cpu_rdata_q;
    gpu_rdata_d = gpu_rdata_q;
    vga_rdata_d = vga_rdata_q;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    rr_d        = rr_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        wait_cnt_d = '0;
        if (bus.vga_read) begin
          grant_d    = REQ_VGA;
          is_write_d = 1'b0;
          addr_d     = bus.vga_addr;
          state_d    = ST_ISSUE;
        end else if (pick_cpu) begin
          grant_d    = REQ_CPU;
          is_write_d = cpu_wvalid;
          addr_d     = cpu_wvalid ? cpu_waddr : bus.cpu_read_addr;
          if (cpu_wvalid) wdata_d = cpu_wdata;
          state_d    = ST_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d       = 1'b1;
`endif
        end else if (pick_gpu) begin
          grant_d    = REQ_GPU;
          is_write_d = gpu_wvalid;
          addr_d     = gpu_wvalid ? gpu_waddr : bus.gpu_read_addr;
          if (gpu_wvalid) wdata_d = gpu_wdata;
          state_d    = ST_ISSUE;
`ifdef MEM_ARB_ROUND_ROBIN_EN
          rr_d       = 1'b0;
`endif
        end
      end
      ST_ISSUE: state_d = is_write_q ? ST_IDLE : ST_WAIT;
      ST_WAIT: begin
        if (wait_cnt_q == WAIT_LAST) begin
          state_d = ST_ACK;
          case (grant_q)
            REQ_CPU: cpu_rdata_d = bus.ram_rdata;
            REQ_GPU: gpu_rdata_d = bus.ram_rdata;
            default: vga_rdata_d = bus.ram_rdata;
          endcase
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.ram_en        = (state_q == ST_ISSUE);
    bus.ram_we        = (state_q == ST_ISSUE) && is_write_q;
    bus.ram_addr      = addr_q;
    bus.ram_wdata     = wdata_q;
    cpu_drain         = (state_q == ST_ISSUE) && is_write_q && (grant_q == REQ_CPU);
    gpu_drain         = (state_q == ST_ISSUE) && is_write_q && (grant_q == REQ_GPU);
    bus.cpu_read_ack  = (state_q == ST_ACK) && (grant_q == REQ_CPU);
    bus.gpu_read_ack  = (state_q == ST_ACK) && (grant_q == REQ_GPU);
    bus.vga_ack       = (state_q == ST_ACK) && (grant_q == REQ_VGA);
    bus.cpu_read_data = cpu_rdata_q;
    bus.gpu_read_data = gpu_rdata_q;
    bus.vga_data      = vga_rdata_q;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port 4 KiB CHIP-8 RAM between three requesters: CPU (read/write), GPU (read/write) and VGA scanout (read only). Sits between cpu/gpu/vga and a plain synchronous RAM macro, and replaces the per-port logic inside memory. Each requester keeps its existing read/read_ack handshake. Writes are buffered one-deep per requester.

Parameters:
ADDR_W, 12, address width (4096 bytes)
DATA_W, 8, data width
RAM_LATENCY, 1, cycles from ram_en to ram_rdata valid (1..3)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
cpu_read  in  1  CPU read request, level, held until cpu_read_ack
cpu_read_addr  in  ADDR_W  CPU read address, stable while cpu_read high
cpu_read_data  out  DATA_W  CPU read data, valid with cpu_read_ack
cpu_read_ack  out  1  one-cycle read completion pulse
cpu_write  in  1  CPU write strobe, accepted when cpu_write_ready
cpu_write_addr  in  ADDR_W  CPU write address
cpu_write_data  in  DATA_W  CPU write data
cpu_write_ready  out  1  CPU write buffer empty
gpu_read / gpu_read_addr / gpu_read_data / gpu_read_ack  same as CPU read ports, for the GPU
gpu_write / gpu_write_addr / gpu_write_data / gpu_write_ready  same as CPU write ports, for the GPU
vga_read  in  1  VGA read request, level
vga_addr  in  ADDR_W  VGA address
vga_data  out  DATA_W  VGA read data
vga_ack  out  1  VGA completion pulse
ram_en  out  1  RAM access strobe
ram_we  out  1  RAM write enable (qualified by ram_en)
ram_addr  out  ADDR_W  RAM address
ram_wdata  out  DATA_W  RAM write data
ram_rdata  in  DATA_W  RAM read data, valid RAM_LATENCY cycles after ram_en

Behaviour:
- Reset values: all acks 0, all data outputs 0, ram_en/ram_we 0, ram_addr/ram_wdata 0, both write_ready 1, FSM in IDLE, write buffers empty, round-robin pointer at CPU.
- Write buffer: on `write && write_ready`, the address and data are captured. write_ready drops on the next cycle and stays low until the buffered write has issued to RAM. A write strobe while ready=0 is ignored. Requesters must not strobe while not ready.
- FSM states: IDLE -> ISSUE -> WAIT -> ACK -> IDLE. Write grants go IDLE -> ISSUE -> IDLE.
- IDLE: a grant is picked from the pending set at this clock edge.
  - Priority: VGA read first, then CPU/GPU. CPU wins over GPU (fixed priority, unless the optional feature is enabled).
  - Within one requester, a buffered write is served before that requester's read. This guarantees read-after-write to the same address returns the new data.
  - The granted address, data and kind are latched.
- ISSUE: one cycle with ram_en=1, and ram_we=1 for writes.
  - Write: the write buffer empties (write_ready returns to 1 on the next cycle), then back to IDLE.
  - Read: go to WAIT.
- WAIT: count RAM_LATENCY-1 cycles. When ram_rdata is valid, register it and go to ACK.
- ACK: the granted requester's ack is high for exactly one cycle, with data on its data port. Data holds until that requester's next ack. Then back to IDLE.
- Requesters deassert read in the cycle after ack. The arbiter ignores read during ACK, so no double service.
- Uncontended read latency: ack is high in cycle 2+RAM_LATENCY after the cycle where read is first high (cycle 3 for RAM_LATENCY=1).
- Throughput: one write per 2 cycles; one read per 3+RAM_LATENCY cycles.
- Requests arriving mid-transaction wait in IDLE arbitration. Simultaneous requests are resolved purely by priority.
- VGA starvation of CPU/GPU is tolerated; scanout is sparse.
- rst_n low mid-transaction: all state clears asynchronously. Pending writes are discarded, and no ack is issued for in-flight reads.
- ram_addr and ram_wdata hold their last value outside ISSUE.

Optional Feature:
MEM_ARB_ROUND_ROBIN_EN:
- Defined: CPU vs GPU arbitration is round-robin. A 1-bit pointer moves to the non-granted requester after each CPU/GPU grant. VGA keeps absolute priority.
- Undefined: fixed priority, CPU over GPU. The pointer logic is not compiled.

Decomposition:
- Shared package/header (alongside utils.v): ADDR_W/DATA_W defaults, FSM state encodings (ST_IDLE, ST_ISSUE, ST_WAIT, ST_ACK), requester IDs (REQ_CPU=0, REQ_GPU=1, REQ_VGA=2).
- One sub-module: mem_arb_wbuf, the one-entry write buffer (capture, ready, drain). Instantiated twice, for CPU and GPU.

Test Plan:
- Uncontended CPU read, RAM[0x200]=0xA2, RAM_LATENCY=1: cpu_read at cycle 0 -> ram_en cycle 1, cpu_read_ack + cpu_read_data=0xA2 at cycle 3, single pulse.
- CPU write 0x55 to 0x300, then CPU read of 0x300 the next cycle -> write issues first; read returns 0x55; cpu_write_ready low for exactly 2 cycles.
- CPU, GPU and VGA reads asserted in the same cycle -> service order VGA, CPU, GPU; each ack is a one-cycle pulse carrying its own data.
- With MEM_ARB_ROUND_ROBIN_EN, CPU and GPU both continuously requesting for 4 grants -> grants alternate CPU, GPU, CPU, GPU. Without the macro -> CPU, CPU, CPU, CPU.
- GPU write strobed while gpu_write_ready=0 -> ignored; RAM unchanged at the second address.
- rst_n pulled low in WAIT during a GPU read -> no gpu_read_ack, all outputs at reset values, write_ready=1. After release, a fresh read completes normally.
